// File: rtl/apb_pkg.sv
// Shared types and default constants for the APB requester bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  // Why a transfer ended in error; kept as a named signal for debug visibility.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SLVERR,
    ERR_DECERR,
    ERR_TIMEOUT
  } err_cause_e;

  localparam logic [31:0]  DEF_BASE_ADDR  = 32'h1000_0000;
  localparam int unsigned  DEF_SLOT_SHIFT = 10;

  // Width of a slot index; a single-slot bridge still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_slot_decoder.sv
// Base-relative slot decode: fixed-size slots starting at BASE_ADDR.
module apb_slot_decoder
  import apb_pkg::*;
#(
  parameter int unsigned             NUM_SLV    = 16,
  parameter int unsigned             ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]       BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned             SLOT_SHIFT = DEF_SLOT_SHIFT,
  localparam int unsigned            IDX_W      = idx_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] slot;

  // Offset from the base, full slot number, then range check against the slot count.
  always_comb begin
    off  = addr - BASE_ADDR;
    slot = off >> SLOT_SHIFT;
    hit  = (addr >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLV));
    idx  = IDX_W'(slot);
  end

endmodule

// File: rtl/apb_master_param.sv
// APB4 requester bridge from the single-request internal bus to NUM_SLV slots.
module apb_master_param
  import apb_pkg::*;
#(
  parameter int unsigned       NUM_SLV    = 16,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       SLOT_SHIFT = DEF_SLOT_SHIFT,
  parameter int unsigned       TIMEOUT    = 255
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       strb,
  output logic                      ready,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      busy
);

  localparam int unsigned IDX_W = idx_width(NUM_SLV);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_e        state_q, state_d;
  err_cause_e        cause_d;
  logic [IDX_W-1:0]  dec_idx, idx_q, idx_d;
  logic              dec_hit, hit_q, hit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] prdata_sel;
  logic              pready_sel;
  logic              pslverr_sel;

  apb_slot_decoder #(
    .NUM_SLV    (NUM_SLV),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR),
    .SLOT_SHIFT (SLOT_SHIFT)
  ) u_dec (
    .addr (addr),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  // Response mux for the slot latched at acceptance.
  always_comb begin
    prdata_sel  = PRDATA[int'(idx_q) * int'(DATA_W) +: DATA_W];
    pready_sel  = PREADY[idx_q];
    pslverr_sel = PSLVERR[idx_q];
  end

  // Next-state, completion status and wait-state counter.
  always_comb begin
    state_d = state_q;
    cause_d = ERR_NONE;
    rdata_d = '0;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          accept = 1'b1;
          if (dec_hit) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RESP;
            cause_d = ERR_DECERR;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // PREADY takes priority over a timeout landing in the same cycle.
        if (pready_sel) begin
          state_d = ST_RESP;
          cause_d = pslverr_sel ? ERR_SLVERR : ERR_NONE;
          rdata_d = PWRITE ? '0 : prdata_sel;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d = ST_RESP;
          cause_d = ERR_TIMEOUT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot chosen for the APB cycle that is starting or continuing.
  always_comb begin
    idx_d = accept ? dec_idx : idx_q;
    hit_d = accept ? dec_hit : hit_q;
  end

  // State register and wait-state counter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latches; APB address/data phase signals hold until the next acceptance.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
      PSTRB  <= '0;
      idx_q  <= '0;
      hit_q  <= 1'b0;
    end else if (accept) begin
      PADDR  <= addr;
      PWDATA <= wdata;
      PWRITE <= write;
      PSTRB  <= write ? strb : '0;
      idx_q  <= dec_idx;
      hit_q  <= dec_hit;
    end
  end

  // Registered APB control and completion outputs, driven from the next state.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL    <= '0;
      PENABLE <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
    end else begin
      PSEL    <= (hit_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS)))
                 ? (NUM_SLV'(1) << idx_d) : '0;
      PENABLE <= (state_d == ST_ACCESS);
      ready   <= (state_d == ST_RESP);
      err     <= (state_d == ST_RESP) && (cause_d != ERR_NONE);
      busy    <= (state_d != ST_IDLE);
      if (state_d == ST_RESP) begin
        rdata <= rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_param.sv
// Self-checking bench for apb_master_param: vector table plus completion scoreboard.
module tb_apb_master_param;

  localparam int NS = 16;
  localparam int DW = 32;
  localparam int AW = 32;

  logic             PCLK = 1'b0;
  logic             PRESET = 1'b1;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic [DW/8-1:0]  PSTRB;
  logic             PWRITE;
  logic             PENABLE;
  logic [NS-1:0]    PSEL;
  logic [NS*DW-1:0] PRDATA;
  logic [NS-1:0]    PREADY;
  logic [NS-1:0]    PSLVERR;
  logic             transfer = 1'b0;
  logic             write = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [DW-1:0]    wdata = '0;
  logic [DW/8-1:0]  strb = '0;
  logic             ready;
  logic [DW-1:0]    rdata;
  logic             err;
  logic             busy;

  apb_master_param #(
    .NUM_SLV    (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .BASE_ADDR  (32'h1000_0000),
    .SLOT_SHIFT (10),
    .TIMEOUT    (8)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .strb     (strb),
    .ready    (ready),
    .rdata    (rdata),
    .err      (err),
    .busy     (busy)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          slot;
    int          waits;
    logic        slverr;
    logic [31:0] sdata;
    int          lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [15:0] exp_psel;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;

  // Slave model configuration for the slot under test.
  int          cur_slot = 0;
  int          cur_waits = 0;
  logic        cur_slverr = 1'b0;
  logic [31:0] cur_rdata = '0;

  always @(posedge PCLK) cyc <= cyc + 1;
  always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

  // Slave responses: ready after cur_waits access cycles, other slots return junk.
  always_comb begin
    PRDATA = '0;
    for (int i = 0; i < NS; i++) begin
      PRDATA[i*DW +: DW] = (i == cur_slot) ? cur_rdata : (32'hBAD0_0000 | 32'(i));
    end
    PREADY  = (PENABLE && (acc_cnt == cur_waits)) ? (16'(1) << cur_slot) : '0;
    PSLVERR = cur_slverr ? (16'(1) << cur_slot) : '0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Completion monitor: every ready pulse must match the oldest expected response.
  always @(negedge PCLK) begin
    exp_t e;
    chk("psel_onehot", 64'($countones(PSEL) <= 1), 64'd1);
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        chk("err", 64'(err), 64'(e.err));
        chk("rdata", 64'(rdata), 64'(e.rdata));
      end
    end
  end

  task automatic wait_done(input int id);
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      transfer = 1'b0;
      #1;
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL v%0d_complete: actual=pending(%0d) required=done", id, sb.size());
      sb.delete();
    end else begin
      chk($sformatf("v%0d_psel_resp", id), 64'(PSEL), 64'd0);
      chk($sformatf("v%0d_penable_resp", id), 64'(PENABLE), 64'd0);
    end
  endtask

  task automatic issue(input vec_t v, input int id);
    exp_t e;
    @(negedge PCLK);
    cur_slot   = v.slot;
    cur_waits  = v.waits;
    cur_slverr = v.slverr;
    cur_rdata  = v.sdata;
    write      = v.wr;
    addr       = v.addr;
    wdata      = v.wdata;
    strb       = v.strb;
    transfer   = 1'b1;
    e.cyc      = cyc + v.lat;
    e.err      = v.exp_err;
    e.rdata    = v.exp_rdata;
    sb.push_back(e);
    for (int k = 1; k < v.lat; k++) begin
      @(negedge PCLK);
      transfer = 1'b0;
      chk($sformatf("v%0d_psel_c%0d", id, k), 64'(PSEL), 64'(v.exp_psel));
      chk($sformatf("v%0d_penable_c%0d", id, k), 64'(PENABLE), 64'(k > 1));
      chk($sformatf("v%0d_busy_c%0d", id, k), 64'(busy), 64'd1);
      if (k == 1) begin
        chk($sformatf("v%0d_paddr", id), 64'(PADDR), 64'(v.addr));
        chk($sformatf("v%0d_pwrite", id), 64'(PWRITE), 64'(v.wr));
        chk($sformatf("v%0d_pwdata", id), 64'(PWDATA), 64'(v.wdata));
        chk($sformatf("v%0d_pstrb", id), 64'(PSTRB), 64'(v.wr ? v.strb : 4'h0));
      end
    end
    wait_done(id);
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] sb_, input int slot, input int waits,
                              input logic se, input logic [31:0] sd, input int lat,
                              input logic ee, input logic [31:0] er, input logic [15:0] ep);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.strb = sb_; v.slot = slot; v.waits = waits;
    v.slverr = se; v.sdata = sd; v.lat = lat; v.exp_err = ee; v.exp_rdata = er; v.exp_psel = ep;
    return v;
  endfunction

  vec_t vt[10];

  initial begin
    exp_t e;
    vt[0] = mk(1'b1, 32'h1000_0800, 32'hDEAD_BEEF, 4'hF,  2,  0, 1'b0, 32'h9999_9999,  3, 1'b0, 32'h0,         16'h0004);
    vt[1] = mk(1'b0, 32'h1000_1404, 32'h0,         4'hF,  5,  3, 1'b0, 32'h1234_5678,  6, 1'b0, 32'h1234_5678, 16'h0020);
    vt[2] = mk(1'b0, 32'h2000_0000, 32'h0,         4'h0,  0,  0, 1'b0, 32'h4444_4444,  1, 1'b1, 32'h0,         16'h0000);
    vt[3] = mk(1'b0, 32'h1000_0000, 32'h0,         4'h0,  0, 99, 1'b0, 32'h7777_7777, 10, 1'b1, 32'h0,         16'h0001);
    vt[4] = mk(1'b0, 32'h1000_0000, 32'h0,         4'h0,  0,  0, 1'b0, 32'hCAFE_0001,  3, 1'b0, 32'hCAFE_0001, 16'h0001);
    vt[5] = mk(1'b0, 32'h1000_3FFC, 32'h0,         4'h0, 15,  1, 1'b0, 32'h5A5A_1515,  4, 1'b0, 32'h5A5A_1515, 16'h8000);
    vt[6] = mk(1'b0, 32'h0FFF_FFFC, 32'h0,         4'h0,  0,  0, 1'b0, 32'h6666_6666,  1, 1'b1, 32'h0,         16'h0000);
    vt[7] = mk(1'b0, 32'h1000_4000, 32'h0,         4'h0,  0,  0, 1'b0, 32'h6666_6666,  1, 1'b1, 32'h0,         16'h0000);
    vt[8] = mk(1'b1, 32'h1000_1000, 32'h0000_ABCD, 4'h3,  4,  2, 1'b0, 32'h8888_8888,  5, 1'b0, 32'h0,         16'h0010);
    vt[9] = mk(1'b0, 32'h1000_0400, 32'h0,         4'h0,  1,  7, 1'b0, 32'h1111_2222, 10, 1'b0, 32'h1111_2222, 16'h0002);

    // Reset state.
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pstrb", 64'(PSTRB), 64'd0);
    PRESET = 1'b0;

    for (int i = 0; i < 10; i++) issue(vt[i], i);

    // Slave error on a write, then a read raised during the ready cycle.
    @(negedge PCLK);
    cur_slot = 3; cur_waits = 0; cur_slverr = 1'b1; cur_rdata = 32'h3333_3333;
    write = 1'b1; addr = 32'h1000_0C00; wdata = 32'h5555_AAAA; strb = 4'hF; transfer = 1'b1;
    e.cyc = cyc + 3; e.err = 1'b1; e.rdata = 32'h0;
    sb.push_back(e);
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("b2b_wr_ready", 64'(ready), 64'd1);
    cur_slverr = 1'b0; cur_rdata = 32'h0BAD_F00D;
    write = 1'b0; addr = 32'h1000_0C04; transfer = 1'b1;
    e.cyc = cyc + 4; e.err = 1'b0; e.rdata = 32'h0BAD_F00D;
    sb.push_back(e);
    @(negedge PCLK);
    chk("b2b_idle_busy", 64'(busy), 64'd0);
    chk("b2b_idle_psel", 64'(PSEL), 64'd0);
    @(negedge PCLK);
    transfer = 1'b0;
    chk("b2b_rd_psel", 64'(PSEL), 64'h0008);
    chk("b2b_rd_pwrite", 64'(PWRITE), 64'd0);
    chk("b2b_rd_pstrb", 64'(PSTRB), 64'd0);
    wait_done(100);

    // Reset in the middle of a slot-1 access: request is dropped silently.
    @(negedge PCLK);
    cur_slot = 1; cur_waits = 99; cur_rdata = 32'hFEED_0001;
    write = 1'b0; addr = 32'h1000_0400; transfer = 1'b1;
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_mid_penable_before", 64'(PENABLE), 64'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_mid_psel", 64'(PSEL), 64'd0);
    chk("rst_mid_penable", 64'(PENABLE), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(ready), 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    issue(mk(1'b0, 32'h1000_0400, 32'h0, 4'h0, 1, 0, 1'b0, 32'h0404_0404, 3, 1'b0, 32'h0404_0404, 16'h0002), 101);

    repeat (3) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
